id_ex_pipe_reg: RTL and testbench

- Pipeline register between the decode stage (control unit, register file read, immediate generator) and the execute stage.
- Captures decoded control signals and operands each cycle.
- Detects load-use hazards against the instruction currently in EX and inserts bubbles.
- Honours a downstream stall and a branch/jump flush from EX.

---
 rtl/id_ex_pipe_reg_pkg.sv | 61 ++++++
 rtl/id_ex_hazard_detect.sv | 35 +++
 rtl/id_ex_pipe_reg.sv | 184 ++++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg_pkg
// Description : Shared encodings for the ID/EX boundary: load/store type
//               codes, opcode/func constants, the decoded-control bundle
//               type and the bubble value of that bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_pipe_reg_pkg;

    // Load type encodings (LOAD_DEF marks "no load" / bubble)
    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;
    localparam logic [2:0] LOAD_DEF = 3'b111;

    // Store type encodings (STORE_DEF marks "no store" / bubble)
    localparam logic [1:0] STORE_SB  = 2'b00;
    localparam logic [1:0] STORE_SH  = 2'b01;
    localparam logic [1:0] STORE_SW  = 2'b10;
    localparam logic [1:0] STORE_DEF = 2'b11;

    // Opcode / func constants shared with the decoder
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [6:0] F7_ADD     = 7'h00;
    localparam logic [6:0] F7_SUB     = 7'h20;

    // Decoded control bundle carried from ID to EX
    typedef struct packed {
        logic       ex_alu_src;
        logic       mem_write;
        logic       wb_load;
        logic       wb_reg_file;
        logic [2:0] mem_load_type;
        logic [1:0] mem_store_type;
    } ctrl_t;

    // Control value of a bubble: no memory or register-file side effects
    localparam ctrl_t BUBBLE_CTRL = '{
        ex_alu_src:     1'b0,
        mem_write:      1'b0,
        wb_load:        1'b0,
        wb_reg_file:    1'b0,
        mem_load_type:  LOAD_DEF,
        mem_store_type: STORE_DEF
    };

    // An invalid instruction must never carry live controls into EX
    function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic valid);
        return valid ? c : BUBBLE_CTRL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_hazard_detect
// Description : Combinational load-use hazard detection between the
//               instruction in EX and the one in decode. Kept separate so a
//               forwarding unit can reuse it.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_wb_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_flush,
    input  logic              id_valid,
    input  logic              id_uses_rs1,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              hazard,
    output logic              load_use_stall
);

    // A live load to a non-x0 register feeding a real source operand; a
    // flush kills the decode instruction so no stall is needed then.
    always_comb begin
        hazard = ex_valid && ex_wb_load && (ex_rd != '0) && id_valid &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                  (id_uses_rs2 && (id_rs2 == ex_rd)));
        load_use_stall = hazard && !ex_flush;
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : ID/EX pipeline register with load-use bubble insertion,
//               downstream stall hold and EX-redirect flush.
//               Optional macro ID_EX_PERF_EN adds saturating bubble/flush
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [2:0]        id_func3,
    input  logic [6:0]        id_func7,
    input  logic              id_ex_alu_src,
    input  logic              id_mem_write,
    input  logic              id_wb_load,
    input  logic              id_wb_reg_file,
    input  logic [2:0]        id_mem_load_type,
    input  logic [1:0]        id_mem_store_type,
    input  logic              ex_stall,
    input  logic              ex_flush,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [2:0]        ex_func3,
    output logic [6:0]        ex_func7,
    output logic              ex_ex_alu_src,
    output logic              ex_mem_write,
    output logic              ex_wb_load,
    output logic              ex_wb_reg_file,
    output logic [2:0]        ex_mem_load_type,
    output logic [1:0]        ex_mem_store_type
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic [2:0]        r_func3;
    logic [6:0]        r_func7;
    ctrl_t             r_ctrl;

    logic              w_hazard;
    ctrl_t             w_id_ctrl;

    assign w_id_ctrl = '{
        ex_alu_src:     id_ex_alu_src,
        mem_write:      id_mem_write,
        wb_load:        id_wb_load,
        wb_reg_file:    id_wb_reg_file,
        mem_load_type:  id_mem_load_type,
        mem_store_type: id_mem_store_type
    };

    id_ex_hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .ex_valid       (r_valid),
        .ex_wb_load     (r_ctrl.wb_load),
        .ex_rd          (r_rd),
        .ex_flush       (ex_flush),
        .id_valid       (id_valid),
        .id_uses_rs1    (id_uses_rs1),
        .id_rs1         (id_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_rs2         (id_rs2),
        .hazard         (w_hazard),
        .load_use_stall (load_use_stall)
    );

    // Register bank: flush beats stall beats hazard bubble beats capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_func3    <= '0;
            r_func7    <= '0;
            r_ctrl     <= BUBBLE_CTRL;
        end else if (ex_flush || (!ex_stall && w_hazard)) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_func3    <= '0;
            r_func7    <= '0;
            r_ctrl     <= BUBBLE_CTRL;
        end else if (!ex_stall) begin
            r_valid    <= id_valid;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_func3    <= id_func3;
            r_func7    <= id_func7;
            r_ctrl     <= ctrl_gate(w_id_ctrl, id_valid);
        end
    end

    assign ex_valid          = r_valid;
    assign ex_pc             = r_pc;
    assign ex_rs1_data       = r_rs1_data;
    assign ex_rs2_data       = r_rs2_data;
    assign ex_imm            = r_imm;
    assign ex_rs1            = r_rs1;
    assign ex_rs2            = r_rs2;
    assign ex_rd             = r_rd;
    assign ex_func3          = r_func3;
    assign ex_func7          = r_func7;
    assign ex_ex_alu_src     = r_ctrl.ex_alu_src;
    assign ex_mem_write      = r_ctrl.mem_write;
    assign ex_wb_load        = r_ctrl.wb_load;
    assign ex_wb_reg_file    = r_ctrl.wb_reg_file;
    assign ex_mem_load_type  = r_ctrl.mem_load_type;
    assign ex_mem_store_type = r_ctrl.mem_store_type;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating counters; a stall suppresses counting unless flushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (ex_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (!ex_flush && !ex_stall && w_hazard && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign perf_bubble_cnt = r_bubble_cnt;
    assign perf_flush_cnt  = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipe_reg
// Description : Scoreboard bench for id_ex_pipe_reg. The driver pushes the
//               hand-chosen expected EX state per cycle; a monitor pops it.
//               Build with ID_EX_PERF_EN to also cover the perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;
    import id_ex_pipe_reg_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int K_CAP  = 0;
    localparam int K_BUB  = 1;
    localparam int K_HOLD = 2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] r1d;
        logic [31:0] r2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        u1;
        logic        u2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        alu_src;
        logic        mw;
        logic        wl;
        logic        wrf;
        logic [2:0]  lt;
        logic [1:0]  st;
    } instr_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] r1d;
        logic [31:0] r2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        alu_src;
        logic        mw;
        logic        wl;
        logic        wrf;
        logic [2:0]  lt;
        logic [1:0]  st;
    } exp_t;

    typedef struct packed {
        exp_t e;
        logic luse;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid = 1'b0;
    logic [XLEN-1:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [REG_AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic [2:0] id_func3 = '0;
    logic [6:0] id_func7 = '0;
    logic id_ex_alu_src = 1'b0, id_mem_write = 1'b0, id_wb_load = 1'b0, id_wb_reg_file = 1'b0;
    logic [2:0] id_mem_load_type = LOAD_DEF;
    logic [1:0] id_mem_store_type = STORE_DEF;
    logic ex_stall = 1'b0, ex_flush = 1'b0;

    logic load_use_stall, ex_valid;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [2:0] ex_func3;
    logic [6:0] ex_func7;
    logic ex_ex_alu_src, ex_mem_write, ex_wb_load, ex_wb_reg_file;
    logic [2:0] ex_mem_load_type;
    logic [1:0] ex_mem_store_type;
`ifdef ID_EX_PERF_EN
    logic [31:0] perf_bubble_cnt, perf_flush_cnt;
`endif

    id_ex_pipe_reg #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .id_func3(id_func3), .id_func7(id_func7),
        .id_ex_alu_src(id_ex_alu_src), .id_mem_write(id_mem_write),
        .id_wb_load(id_wb_load), .id_wb_reg_file(id_wb_reg_file),
        .id_mem_load_type(id_mem_load_type), .id_mem_store_type(id_mem_store_type),
        .ex_stall(ex_stall), .ex_flush(ex_flush), .load_use_stall(load_use_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_func3(ex_func3), .ex_func7(ex_func7),
        .ex_ex_alu_src(ex_ex_alu_src), .ex_mem_write(ex_mem_write),
        .ex_wb_load(ex_wb_load), .ex_wb_reg_file(ex_wb_reg_file),
        .ex_mem_load_type(ex_mem_load_type), .ex_mem_store_type(ex_mem_store_type)
`ifdef ID_EX_PERF_EN
        , .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    rec_t sb_q[$];
    exp_t last_exp;

    function automatic exp_t actual();
        exp_t a;
        a = '{ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
              ex_func3, ex_func7, ex_ex_alu_src, ex_mem_write, ex_wb_load, ex_wb_reg_file,
              ex_mem_load_type, ex_mem_store_type};
        return a;
    endfunction

    function automatic exp_t bubble_exp();
        exp_t e;
        e = '0;
        e.lt = LOAD_DEF;
        e.st = STORE_DEF;
        return e;
    endfunction

    function automatic exp_t cap_exp(input instr_t i);
        exp_t e;
        e = '{i.valid, i.pc, i.r1d, i.r2d, i.imm, i.rs1, i.rs2, i.rd, i.f3, i.f7,
              i.alu_src, i.mw, i.wl, i.wrf, i.lt, i.st};
        if (!i.valid) begin
            e.alu_src = 1'b0; e.mw = 1'b0; e.wl = 1'b0; e.wrf = 1'b0;
            e.lt = LOAD_DEF;  e.st = STORE_DEF;
        end
        return e;
    endfunction

    function automatic instr_t mk_alu(input logic [31:0] pc, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [4:0] rd);
        instr_t i;
        i = '0;
        i.valid = 1'b1; i.pc = pc; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
        i.u1 = 1'b1; i.u2 = 1'b1; i.r1d = pc ^ 32'hA5A5_0000; i.r2d = pc ^ 32'h5A5A_0000;
        i.imm = 32'hFFFF_FFFC; i.f3 = F3_ADD_SUB; i.f7 = F7_SUB; i.wrf = 1'b1;
        i.lt = LOAD_DEF; i.st = STORE_DEF;
        return i;
    endfunction

    function automatic instr_t mk_load(input logic [31:0] pc, input logic [4:0] rd);
        instr_t i;
        i = mk_alu(pc, 5'd1, 5'd9, rd);
        i.u2 = 1'b0; i.alu_src = 1'b1; i.wl = 1'b1; i.f3 = 3'b010; i.f7 = 7'h00;
        i.lt = LOAD_LW; i.imm = 32'h0000_0010;
        return i;
    endfunction

    function automatic instr_t mk_store(input logic [31:0] pc);
        instr_t i;
        i = mk_alu(pc, 5'd2, 5'd3, 5'd0);
        i.alu_src = 1'b1; i.mw = 1'b1; i.wrf = 1'b0; i.f3 = 3'b010; i.f7 = 7'h00;
        i.st = STORE_SW; i.imm = 32'h0000_0008;
        return i;
    endfunction

    task automatic check_state(input string name, input exp_t exp);
        exp_t a;
        a = actual();
        checks++;
        if (a !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, a, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Drive one decode cycle and push the expected EX state for the next edge
    task automatic step(input instr_t i, input logic fl, input logic stl,
                        input int kind, input logic exp_luse);
        rec_t r;
        @(posedge clk);
        #2;
        id_valid = i.valid; id_pc = i.pc; id_rs1_data = i.r1d; id_rs2_data = i.r2d;
        id_imm = i.imm; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
        id_uses_rs1 = i.u1; id_uses_rs2 = i.u2; id_func3 = i.f3; id_func7 = i.f7;
        id_ex_alu_src = i.alu_src; id_mem_write = i.mw; id_wb_load = i.wl;
        id_wb_reg_file = i.wrf; id_mem_load_type = i.lt; id_mem_store_type = i.st;
        ex_flush = fl; ex_stall = stl;
        case (kind)
            K_CAP:   r.e = cap_exp(i);
            K_BUB:   r.e = bubble_exp();
            default: r.e = last_exp;
        endcase
        r.luse = exp_luse;
        last_exp = r.e;
        sb_q.push_back(r);
    endtask

    // Monitor: stall flag checked mid-cycle, EX state checked after the edge
    initial begin
        rec_t r;
        int   n;
        n = 0;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                r = sb_q[0];
                check_bit($sformatf("load_use_stall[%0d]", n), load_use_stall, r.luse);
                @(posedge clk);
                #1;
                check_state($sformatf("ex_state[%0d]", n), r.e);
                checks++;
                if (!ex_valid && (ex_mem_write || ex_wb_reg_file)) begin
                    failures++;
                    $display("FAIL bubble_invariant[%0d]: mw=%b wrf=%b want 0 0", n,
                             ex_mem_write, ex_wb_reg_file);
                end
                void'(sb_q.pop_front());
                n++;
            end
        end
    end

    initial begin
        instr_t a, ld, use5, inv;
        int     waited;
        last_exp = bubble_exp();

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_state("reset_state", bubble_exp());
        @(negedge clk);
        rst_n = 1'b1;

        // Normal flow
        a = mk_alu(32'h100, 5'd1, 5'd2, 5'd3);
        step(a, 1'b0, 1'b0, K_CAP, 1'b0);
        // Load-use: one bubble, then the consumer enters EX
        ld   = mk_load(32'h104, 5'd5);
        use5 = mk_alu(32'h108, 5'd6, 5'd5, 5'd7);
        step(ld,   1'b0, 1'b0, K_CAP, 1'b0);
        step(use5, 1'b0, 1'b0, K_BUB, 1'b1);
        step(use5, 1'b0, 1'b0, K_CAP, 1'b0);
        // x0 destination never hazards
        step(mk_load(32'h10C, 5'd0), 1'b0, 1'b0, K_CAP, 1'b0);
        step(mk_alu(32'h110, 5'd0, 5'd0, 5'd8), 1'b0, 1'b0, K_CAP, 1'b0);
        // Unused rs1 matching a load destination
        step(mk_load(32'h114, 5'd5), 1'b0, 1'b0, K_CAP, 1'b0);
        a = mk_alu(32'h118, 5'd5, 5'd9, 5'd10);
        a.u1 = 1'b0;
        step(a, 1'b0, 1'b0, K_CAP, 1'b0);
        // Three stalled cycles with a changing decode PC
        step(mk_alu(32'h200, 5'd1, 5'd2, 5'd3), 1'b0, 1'b1, K_HOLD, 1'b0);
        step(mk_alu(32'h204, 5'd1, 5'd2, 5'd3), 1'b0, 1'b1, K_HOLD, 1'b0);
        step(mk_alu(32'h208, 5'd1, 5'd2, 5'd3), 1'b0, 1'b1, K_HOLD, 1'b0);
        step(mk_alu(32'h20C, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0, K_CAP, 1'b0);
        // Stall together with a hazard: hold, stall flag still raised
        step(mk_load(32'h210, 5'd5), 1'b0, 1'b0, K_CAP, 1'b0);
        step(use5, 1'b0, 1'b1, K_HOLD, 1'b1);
        step(use5, 1'b0, 1'b0, K_BUB, 1'b1);
        step(use5, 1'b0, 1'b0, K_CAP, 1'b0);
        // Stall plus flush: flush wins, store side effect killed
        step(mk_store(32'h220), 1'b0, 1'b0, K_CAP, 1'b0);
        step(mk_store(32'h224), 1'b1, 1'b1, K_BUB, 1'b0);
        // Flush beats hazard: no stall flag, bubble loaded
        step(mk_load(32'h230, 5'd5), 1'b0, 1'b0, K_CAP, 1'b0);
        step(use5, 1'b1, 1'b0, K_BUB, 1'b0);
        // Invalid decode slot: data captured, controls forced to bubble values
        inv = mk_store(32'h240);
        inv.valid = 1'b0;
        inv.wrf = 1'b1;
        step(inv, 1'b0, 1'b0, K_CAP, 1'b0);
        // Live store in EX, then an asynchronous reset mid-cycle
        step(mk_store(32'h244), 1'b0, 1'b0, K_CAP, 1'b0);

        waited = 0;
        while (sb_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end

        @(posedge clk);
        #3;
        check_bit("pre_reset_valid", ex_valid, 1'b1);
`ifdef ID_EX_PERF_EN
        checks++;
        if (perf_bubble_cnt !== 32'd2 || perf_flush_cnt !== 32'd2) begin
            failures++;
            $display("FAIL perf_counts: got bubble=%0d flush=%0d want 2 2",
                     perf_bubble_cnt, perf_flush_cnt);
        end
`endif
        rst_n = 1'b0;
        #1;
        check_state("async_reset_state", bubble_exp());
`ifdef ID_EX_PERF_EN
        checks++;
        if (perf_bubble_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            failures++;
            $display("FAIL perf_reset: got bubble=%0d flush=%0d want 0 0",
                     perf_bubble_cnt, perf_flush_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
